// File: rtl/life_step_controller.sv
// Run/pause/step/load sequencer for the game-of-life cell register.
// Issues one-cycle step_game/load_cells enables and tracks generations since the last load.
module life_step_controller #(
    parameter int N            = 8,
    parameter int GAME_DIVIDER = 1000000,
    parameter int GEN_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_toggle,
    input  logic               step_req,
    input  logic               load_req,
    input  logic [N*N-1:0]     cells_q,
    input  logic [N*N-1:0]     cells_d,
    output logic               step_game,
    output logic               load_cells,
    output logic               halted,
    output logic [2:0]         state_o,
    output logic [GEN_W-1:0]   generation
);

    localparam int                CNT_W    = $clog2(GAME_DIVIDER + 1);
    localparam logic [CNT_W-1:0]  TICK_VAL = CNT_W'(GAME_DIVIDER - 1);
    localparam logic [GEN_W-1:0]  GEN_MAX  = '1;

    if (GAME_DIVIDER < 1) begin : g_bad_divider
        $error("life_step_controller: GAME_DIVIDER must be at least 1");
    end

    typedef enum logic [2:0] {
        S_PAUSED   = 3'd0,
        S_RUNNING  = 3'd1,
        S_STEPPING = 3'd2,
        S_LOADING  = 3'd3,
        S_HALTED   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] w_div_cnt_nxt;
    logic             w_stag;
    logic             w_tick;

    assign w_stag  = (cells_d == cells_q);
    assign w_tick  = (r_div_cnt == TICK_VAL);
    assign state_o = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_PAUSED;
            r_div_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        step_game     = 1'b0;
        load_cells    = 1'b0;
        halted        = 1'b0;
        case (r_state)
            S_PAUSED: begin
                if (load_req) begin
                    w_state_nxt = S_LOADING;
                end else if (run_toggle) begin
                    w_state_nxt   = S_RUNNING;
                    w_div_cnt_nxt = '0;
                end else if (step_req) begin
                    w_state_nxt = S_STEPPING;
                end
            end
            S_LOADING: begin
                load_cells  = 1'b1;
                w_state_nxt = S_PAUSED;
            end
            S_RUNNING: begin
                // A load or pause request in the tick cycle suppresses that cycle's step.
                if (load_req) begin
                    w_state_nxt = S_LOADING;
                end else if (run_toggle) begin
                    w_state_nxt   = S_PAUSED;
                    w_div_cnt_nxt = '0;
                end else begin
                    w_div_cnt_nxt = w_tick ? '0 : r_div_cnt + CNT_W'(1);
                    if (w_tick) begin
                        if (w_stag) begin
                            w_state_nxt = S_HALTED;
                        end else begin
                            step_game = 1'b1;
                        end
                    end
                end
            end
            S_STEPPING: begin
                if (w_stag) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    step_game   = 1'b1;
                    w_state_nxt = S_PAUSED;
                end
            end
            S_HALTED: begin
                halted = 1'b1;
                if (load_req) begin
                    w_state_nxt = S_LOADING;
                end
            end
            default: begin
                w_state_nxt = S_PAUSED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            generation <= '0;
        end else if (r_state == S_LOADING) begin
            generation <= '0;
        end else if (step_game && (generation != GEN_MAX)) begin
            generation <= generation + GEN_W'(1);
        end
    end

endmodule

// File: tb/tb_life_step_controller.sv
// Directed bench for life_step_controller: a vector table on a GAME_DIVIDER=4 instance,
// then async-reset and generation-saturation sequences (second instance, GEN_W=2, GAME_DIVIDER=1).
module tb_life_step_controller;

    localparam int NB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A controls / outputs
    logic              run_a = 1'b0, step_a = 1'b0, load_a = 1'b0;
    logic [NB*NB-1:0]  q_a = '0;
    logic [NB*NB-1:0]  d_a;
    logic              sg_a, lc_a, h_a;
    logic [2:0]        st_a;
    logic [15:0]       gen_a;

    // Instance B controls / outputs
    logic              run_b = 1'b0, step_b = 1'b0, load_b = 1'b0;
    logic [NB*NB-1:0]  q_b = '0;
    logic [NB*NB-1:0]  d_b;
    logic              sg_b, lc_b, h_b;
    logic [2:0]        st_b;
    logic [1:0]        gen_b;

    logic [NB*NB-1:0]  seed_blink, seed_glider, seed_block;
    logic [NB*NB-1:0]  seed_a;

    int unsigned passed = 0;
    int unsigned total  = 0;

    life_step_controller #(.N(NB), .GAME_DIVIDER(4), .GEN_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .run_toggle(run_a), .step_req(step_a), .load_req(load_a),
        .cells_q(q_a), .cells_d(d_a), .step_game(sg_a), .load_cells(lc_a), .halted(h_a),
        .state_o(st_a), .generation(gen_a)
    );

    life_step_controller #(.N(NB), .GAME_DIVIDER(1), .GEN_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .run_toggle(run_b), .step_req(step_b), .load_req(load_b),
        .cells_q(q_b), .cells_d(d_b), .step_game(sg_b), .load_cells(lc_b), .halted(h_b),
        .state_o(st_b), .generation(gen_b)
    );

    function automatic logic [NB*NB-1:0] life(input logic [NB*NB-1:0] c);
        logic [NB*NB-1:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < NB; r++) begin
            for (int k = 0; k < NB; k++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dk = -1; dk <= 1; dk++) begin
                        if ((dr != 0 || dk != 0) && (r + dr) >= 0 && (r + dr) < NB &&
                            (k + dk) >= 0 && (k + dk) < NB)
                            cnt += int'(c[(r + dr) * NB + k + dk]);
                    end
                end
                n[r * NB + k] = (cnt == 3) || (cnt == 2 && c[r * NB + k]);
            end
        end
        return n;
    endfunction

    // Behavioural cell register and next-state logic around each controller
    assign d_a = life(q_a);
    assign d_b = life(q_b);

    always @(posedge clk) begin
        if (lc_a)      q_a <= seed_a;
        else if (sg_a) q_a <= d_a;
        if (lc_b)      q_b <= seed_blink;
        else if (sg_b) q_b <= d_b;
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_a(input string tag, input int unsigned xs, input int unsigned xl,
                         input int unsigned xh, input int unsigned xst, input int unsigned xg);
        chk({tag, " step_game"},  32'(sg_a),  xs);
        chk({tag, " load_cells"}, 32'(lc_a),  xl);
        chk({tag, " halted"},     32'(h_a),   xh);
        chk({tag, " state_o"},    32'(st_a),  xst);
        chk({tag, " generation"}, 32'(gen_a), xg);
    endtask

    typedef struct {
        int unsigned seed;   // 1 blinker, 2 glider, 3 block (used with load)
        logic        run, step, load;
        int unsigned xs, xl, xh, xst, xg;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int unsigned seed, input logic run, input logic step,
                                input logic load, input int unsigned xs, input int unsigned xl,
                                input int unsigned xh, input int unsigned xst,
                                input int unsigned xg);
        vec_t v;
        v.seed = seed; v.run = run; v.step = step; v.load = load;
        v.xs = xs; v.xl = xl; v.xh = xh; v.xst = xst; v.xg = xg;
        tbl.push_back(v);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seed_blink  = '0; seed_blink[2*NB+1] = 1'b1; seed_blink[2*NB+2] = 1'b1; seed_blink[2*NB+3] = 1'b1;
        seed_glider = '0; seed_glider[0*NB+1] = 1'b1; seed_glider[1*NB+2] = 1'b1;
        seed_glider[2*NB+0] = 1'b1; seed_glider[2*NB+1] = 1'b1; seed_glider[2*NB+2] = 1'b1;
        seed_block  = '0; seed_block[1*NB+1] = 1'b1; seed_block[1*NB+2] = 1'b1;
        seed_block[2*NB+1] = 1'b1; seed_block[2*NB+2] = 1'b1;
        seed_a = seed_blink;

        // seed run step load | step load halt state gen
        add(1,0,0,1, 0,0,0,0,0);                                    // 0 load blinker
        add(0,0,0,0, 0,1,0,3,0);                                    // 1 LOADING
        add(0,0,0,0, 0,0,0,0,0);                                    // 2
        add(0,1,0,0, 0,0,0,0,0);                                    // 3 run at t=3
        for (int i = 0; i < 3; i++) add(0,0,0,0, 0,0,0,1,0);        // 4..6
        add(0,0,0,0, 1,0,0,1,0);                                    // 7 t+4
        for (int i = 0; i < 3; i++) add(0,0,0,0, 0,0,0,1,1);        // 8..10
        add(0,0,0,0, 1,0,0,1,1);                                    // 11 t+8
        for (int i = 0; i < 3; i++) add(0,0,0,0, 0,0,0,1,2);        // 12..14
        add(0,0,0,0, 1,0,0,1,2);                                    // 15 t+12
        add(0,1,0,0, 0,0,0,1,3);                                    // 16 pause
        add(0,0,0,0, 0,0,0,0,3);                                    // 17
        add(2,0,0,1, 0,0,0,0,3);                                    // 18 load glider
        add(0,0,0,0, 0,1,0,3,3);                                    // 19 LOADING
        add(0,0,1,0, 0,0,0,0,0);                                    // 20 step_req
        add(0,0,1,0, 1,0,0,2,0);                                    // 21 STEPPING + 2nd req
        add(0,0,0,0, 0,0,0,0,1);                                    // 22 only one step
        add(0,0,0,0, 0,0,0,0,1);                                    // 23
        add(3,0,0,1, 0,0,0,0,1);                                    // 24 load block
        add(0,0,0,0, 0,1,0,3,1);                                    // 25
        add(0,1,0,0, 0,0,0,0,0);                                    // 26 run
        for (int i = 0; i < 3; i++) add(0,0,0,0, 0,0,0,1,0);        // 27..29
        add(0,0,0,0, 0,0,0,1,0);                                    // 30 stagnant tick
        add(0,1,0,0, 0,0,1,4,0);                                    // 31 HALTED, run ignored
        add(0,0,1,0, 0,0,1,4,0);                                    // 32 step ignored
        add(0,0,0,0, 0,0,1,4,0);                                    // 33
        add(1,0,0,1, 0,0,1,4,0);                                    // 34 load blinker
        add(0,0,0,0, 0,1,0,3,0);                                    // 35
        add(0,0,0,0, 0,0,0,0,0);                                    // 36
        add(0,1,1,0, 0,0,0,0,0);                                    // 37 run+step
        for (int i = 0; i < 3; i++) add(0,0,0,0, 0,0,0,1,0);        // 38..40 RUNNING
        add(1,0,0,1, 0,0,0,1,0);                                    // 41 load on tick
        add(0,0,0,0, 0,1,0,3,0);                                    // 42
        add(0,0,0,0, 0,0,0,0,0);                                    // 43
        add(1,1,0,1, 0,0,0,0,0);                                    // 44 load+run
        add(0,0,0,0, 0,1,0,3,0);                                    // 45 LOADING wins
        add(0,0,0,0, 0,0,0,0,0);                                    // 46

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk_a("reset", 0, 0, 0, 0, 0);
        chk("reset B state_o", 32'(st_b), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            run_a = tbl[i].run; step_a = tbl[i].step; load_a = tbl[i].load;
            if (tbl[i].load) begin
                case (tbl[i].seed)
                    2:       seed_a = seed_glider;
                    3:       seed_a = seed_block;
                    default: seed_a = seed_blink;
                endcase
            end
            #1;
            chk_a($sformatf("vec%0d", i), tbl[i].xs, tbl[i].xl, tbl[i].xh, tbl[i].xst, tbl[i].xg);
        end
        @(posedge clk); #1;
        run_a = 1'b0; step_a = 1'b0; load_a = 1'b0;

        // Async reset mid-count while running a blinker
        run_a = 1'b1;
        @(posedge clk); #1; run_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("prerst state_o", 32'(st_a), 1);
        chk("prerst generation", 32'(gen_a), 1);
        #2;
        rst_n = 1'b0;
        load_a = 1'b1;
        #1;
        chk_a("in_reset", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("in_reset load_cells", 32'(lc_a), 0);
        @(negedge clk);
        load_a = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_a($sformatf("post_rst%0d", k), 0, 0, 0, 0, 0);
        end

        // Saturation on the GEN_W=2, GAME_DIVIDER=1 instance
        load_b = 1'b1;
        @(posedge clk); #1; load_b = 1'b0; #1;
        chk("B load_cells", 32'(lc_b), 1);
        @(posedge clk); #1; run_b = 1'b1;
        @(posedge clk); #1; run_b = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("B step%0d step_game", k), 32'(sg_b), 1);
            chk($sformatf("B step%0d generation", k), 32'(gen_b), (k < 3) ? k : 3);
            @(posedge clk); #1;
        end
        run_b = 1'b1;
        @(posedge clk); #1; run_b = 1'b0; #1;
        chk("B paused state_o", 32'(st_b), 0);
        chk("B paused step_game", 32'(sg_b), 0);
        chk("B paused generation", 32'(gen_b), 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
